// File: rtl/hs4_responder_if.sv
// Bundle of the four-phase request side and the valid/ready consumer side
// seen by hs4_responder, plus a debug view of its FSM state.
interface hs4_responder_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
);
  logic             in_req;
  logic [WIDTH-1:0] in_data;
  logic             out_ack;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             in_ready;
  logic             out_full;
  logic             out_stall;
  logic [CNTW-1:0]  out_count;
  logic             dbg_state;

  // Handshakes: in_req/out_ack is four-phase (req up, ack up, req down,
  // ack down, one word per phase); out_valid/in_ready transfers a word on
  // every cycle where both are 1, and out_data is stable while valid waits.
  modport slave (
    input  in_req, in_data, in_ready,
    output out_ack, out_data, out_valid, out_full, out_stall, out_count,
           dbg_state
  );

  modport master (
    output in_req, in_data, in_ready,
    input  out_ack, out_data, out_valid, out_full, out_stall, out_count,
           dbg_state
  );
endinterface

// File: rtl/hs4_responder.sv
// Four-phase req/ack responder that captures one word per request phase into
// a small FIFO and presents the buffered words on a registered valid/ready port.
module hs4_responder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic CP,
  input  logic RST,
  hs4_responder_if.slave bus,
  inout  wire  VDD,
  inout  wire  VSS
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OW-1:0]    r_occ;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_full;
  logic             r_stall;
  logic [CNTW-1:0]  r_count;

  logic             w_full_now;
  logic             w_push;
  logic             w_pop;
  logic             w_stall_next;
  logic [OW-1:0]    w_occ_after_pop;
  logic [OW-1:0]    w_occ_next;
  logic [AW-1:0]    w_rd_next;
  logic [WIDTH-1:0] w_head_next;

  // Fullness uses start-of-cycle occupancy, so a same-cycle pop never frees
  // the slot for a write in that cycle.
  assign w_full_now = (r_occ == OW'(DEPTH));
  assign w_pop      = r_valid & bus.in_ready;

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_stall_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_req) begin
          if (!w_full_now) begin
            w_push       = 1'b1;
            w_state_next = ACK;
          end else begin
            w_stall_next = 1'b1;
          end
        end
      end
      ACK: begin
        if (!bus.in_req) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_occ_after_pop = r_occ - OW'(w_pop);
  assign w_occ_next      = w_occ_after_pop + OW'(w_push);
  assign w_rd_next       = r_rd_ptr + AW'(w_pop);
  // When the FIFO drains to empty in the same cycle as a write, the new head
  // is the incoming word rather than a stale memory entry.
  assign w_head_next     = (w_push && (w_occ_after_pop == '0)) ? bus.in_data
                                                                : r_mem[w_rd_next];

  always_ff @(posedge CP) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_full   <= 1'b0;
      r_stall  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= w_rd_next;
      r_occ    <= w_occ_next;
      r_valid  <= (w_occ_next != '0);
      if (w_occ_next != '0) r_data <= w_head_next;
      r_full   <= (w_occ_next == OW'(DEPTH));
      r_stall  <= w_stall_next;
      r_count  <= r_count + CNTW'(w_push);
    end
  end

  assign bus.out_ack   = (r_state == ACK);
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.out_full  = r_full;
  assign bus.out_stall = r_stall;
  assign bus.out_count = r_count;
  assign bus.dbg_state = r_state;
endmodule
